// File: rtl/washer_fsm.sv
// Washing-machine program controller.
// Sequences fill / wash / drain / rinse / spin from a front-panel start and
// drives the valves, motor, soap dispenser and door lock. Every output is
// either a register or a decode of the registered state.
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | powered down or never started, everything off
// WAIT_SOAP | wash accepted, waiting for detergent in drawer
// FILL      | wash fill, hot or cold inlet, soap dispensed
// WASH      | wash agitation
// DRAIN1    | drain after wash
// RFILL     | rinse fill, cold inlet only
// RINSE     | rinse agitation
// DRAIN2    | drain after rinse
// SPIN      | spin-dry with drain open
// DONE      | program complete, door unlocked
module washer_fsm #(
    parameter int FILL_T  = 10,
    parameter int WASH_T  = 30,
    parameter int DRAIN_T = 10,
    parameter int RINSE_T = 20,
    parameter int SPIN_T  = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       power,
    input  logic [2:0] program_selection,
    input  logic       start,
    input  logic       doorclosed,
    input  logic       soap,
    output logic       valve_in_cold,
    output logic       valve_in_hot,
    output logic       valve_out,
    output logic [1:0] motor,
    output logic [7:0] timer_display,
    output logic       program_done,
    output logic       soap_warning,
    output logic       soap_in,
    output logic       lockDoor
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        WAIT_SOAP = 4'd1,
        FILL      = 4'd2,
        WASH      = 4'd3,
        DRAIN1    = 4'd4,
        RFILL     = 4'd5,
        RINSE     = 4'd6,
        DRAIN2    = 4'd7,
        SPIN      = 4'd8,
        DONE      = 4'd9
    } state_e;

    localparam logic [1:0] PROG_COLD = 2'b00;
    localparam logic [1:0] PROG_HOT  = 2'b01;
    localparam logic [1:0] PROG_RD   = 2'b10;

    state_e     current_state, state_d;
    logic [7:0] timer_q, timer_d;
    logic [1:0] prog_q, prog_d;
    logic       start_ok;

    // Timer reload value is the phase length minus one so that the state
    // changes on the edge where the counter reads zero.
    function automatic logic [7:0] phase_len_m1(state_e s);
        case (s)
            FILL, RFILL:    phase_len_m1 = 8'(FILL_T - 1);
            WASH:           phase_len_m1 = 8'(WASH_T - 1);
            DRAIN1, DRAIN2: phase_len_m1 = 8'(DRAIN_T - 1);
            RINSE:          phase_len_m1 = 8'(RINSE_T - 1);
            SPIN:           phase_len_m1 = 8'(SPIN_T - 1);
            default:        phase_len_m1 = 8'd0;
        endcase
    endfunction

    function automatic state_e next_phase(state_e s);
        case (s)
            FILL:    next_phase = WASH;
            WASH:    next_phase = DRAIN1;
            DRAIN1:  next_phase = RFILL;
            RFILL:   next_phase = RINSE;
            RINSE:   next_phase = DRAIN2;
            DRAIN2:  next_phase = SPIN;
            SPIN:    next_phase = DONE;
            default: next_phase = IDLE;
        endcase
    endfunction

    assign start_ok = power && start && doorclosed && !program_selection[2];

    // State, phase timer and latched program registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            current_state <= IDLE;
            timer_q       <= 8'd0;
            prog_q        <= PROG_COLD;
        end else begin
            current_state <= state_d;
            timer_q       <= timer_d;
            prog_q        <= prog_d;
        end
    end

    // Next-state, timer and program-latch logic; power loss overrides all
    always_comb begin
        state_d = current_state;
        timer_d = timer_q;
        prog_d  = prog_q;
        if (!power) begin
            state_d = IDLE;
            timer_d = 8'd0;
        end else begin
            case (current_state)
                IDLE, DONE: begin
                    if (start_ok) begin
                        prog_d = program_selection[1:0];
                        case (program_selection[1:0])
                            PROG_COLD, PROG_HOT: state_d = soap ? FILL : WAIT_SOAP;
                            PROG_RD:             state_d = RFILL;
                            default:             state_d = SPIN;
                        endcase
                        timer_d = phase_len_m1(state_d);
                    end
                end
                WAIT_SOAP: begin
                    if (soap) begin
                        state_d = FILL;
                        timer_d = phase_len_m1(FILL);
                    end
                end
                default: begin
                    if (timer_q == 8'd0) begin
                        state_d = next_phase(current_state);
                        timer_d = phase_len_m1(state_d);
                    end else begin
                        timer_d = timer_q - 8'd1;
                    end
                end
            endcase
        end
    end

    // Actuator and indicator decode from the registered state
    always_comb begin
        valve_in_cold = 1'b0;
        valve_in_hot  = 1'b0;
        valve_out     = 1'b0;
        motor         = 2'b00;
        program_done  = 1'b0;
        soap_warning  = 1'b0;
        soap_in       = 1'b0;
        lockDoor      = (current_state != IDLE) && (current_state != DONE);
        timer_display = timer_q;
        case (current_state)
            WAIT_SOAP: soap_warning = 1'b1;
            FILL: begin
                valve_in_cold = (prog_q == PROG_COLD);
                valve_in_hot  = (prog_q == PROG_HOT);
                soap_in       = 1'b1;
            end
            WASH, RINSE:    motor = 2'b01;
            RFILL:          valve_in_cold = 1'b1;
            DRAIN1, DRAIN2: valve_out = 1'b1;
            SPIN: begin
                valve_out = 1'b1;
                motor     = 2'b10;
            end
            DONE: program_done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_washer_fsm.sv
// Bench for washer_fsm: expected output vectors are queued from a phase
// schedule when a program is started and compared one per clock.
module tb_washer_fsm;

    localparam int FILL_T  = 10;
    localparam int WASH_T  = 30;
    localparam int DRAIN_T = 10;
    localparam int RINSE_T = 20;
    localparam int SPIN_T  = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       power;
    logic [2:0] program_selection;
    logic       start;
    logic       doorclosed;
    logic       soap;
    logic       valve_in_cold, valve_in_hot, valve_out;
    logic [1:0] motor;
    logic [7:0] timer_display;
    logic       program_done, soap_warning, soap_in, lockDoor;

    int n_checks = 0;
    int n_errors = 0;
    logic [16:0] exp_q[$];

    washer_fsm #(
        .FILL_T (FILL_T),
        .WASH_T (WASH_T),
        .DRAIN_T(DRAIN_T),
        .RINSE_T(RINSE_T),
        .SPIN_T (SPIN_T)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .power            (power),
        .program_selection(program_selection),
        .start            (start),
        .doorclosed       (doorclosed),
        .soap             (soap),
        .valve_in_cold    (valve_in_cold),
        .valve_in_hot     (valve_in_hot),
        .valve_out        (valve_out),
        .motor            (motor),
        .timer_display    (timer_display),
        .program_done     (program_done),
        .soap_warning     (soap_warning),
        .soap_in          (soap_in),
        .lockDoor         (lockDoor)
    );

    always #5 clk = ~clk;

    wire [16:0] obs = {valve_in_cold, valve_in_hot, valve_out, motor, timer_display,
                       program_done, soap_warning, soap_in, lockDoor};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [16:0] ov(input logic cold, input logic hot, input logic vout,
                                       input logic [1:0] mot, input logic [7:0] tmr,
                                       input logic done, input logic warn,
                                       input logic sin, input logic lock);
        return {cold, hot, vout, mot, tmr, done, warn, sin, lock};
    endfunction

    // count entries of a phase of length len, timer counting len-1 downwards
    task automatic push_phase(input logic cold, input logic hot, input logic vout,
                              input logic [1:0] mot, input logic sin, input int len,
                              input int count);
        for (int i = 0; i < count; i++)
            exp_q.push_back(ov(cold, hot, vout, mot, 8'(len - 1 - i), 1'b0, 1'b0, sin, 1'b1));
    endtask

    task automatic push_idle(input int count);
        for (int i = 0; i < count; i++) exp_q.push_back(17'd0);
    endtask

    task automatic push_done();
        exp_q.push_back(ov(1'b0, 1'b0, 1'b0, 2'b00, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    endtask

    task automatic push_spin_done();
        push_phase(1'b0, 1'b0, 1'b1, 2'b10, 1'b0, SPIN_T, SPIN_T);
        push_done();
    endtask

    task automatic push_rinse_dry();
        push_phase(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, FILL_T, FILL_T);
        push_phase(1'b0, 1'b0, 1'b0, 2'b01, 1'b0, RINSE_T, RINSE_T);
        push_phase(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, DRAIN_T, DRAIN_T);
        push_spin_done();
    endtask

    task automatic push_wash(input logic hot);
        push_phase(!hot, hot, 1'b0, 2'b00, 1'b1, FILL_T, FILL_T);
        push_phase(1'b0, 1'b0, 1'b0, 2'b01, 1'b0, WASH_T, WASH_T);
        push_phase(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, DRAIN_T, DRAIN_T);
        push_rinse_dry();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_n(input int n);
        logic [16:0] e;
        for (int i = 0; i < n; i++) begin
            tick();
            if (exp_q.size() == 0) begin
                check("queue_underrun", 32'(exp_q.size()), 32'd1);
                return;
            end
            e = exp_q.pop_front();
            check("outputs", 32'(obs), 32'(e));
        end
    endtask

    task automatic run_all();
        while (exp_q.size() > 0) run_n(1);
    endtask

    initial begin
        rst = 1'b0;
        power = 1'b0;
        program_selection = 3'b000;
        start = 1'b0;
        doorclosed = 1'b1;
        soap = 1'b1;

        // reset state
        #12;
        check("reset_outputs", 32'(obs), 32'd0);
        check("reset_state", 32'(dut.current_state), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        power = 1'b1;
        tick();

        // cold wash with soap; selection change after start must be ignored
        program_selection = 3'b000;
        start = 1'b1;
        push_wash(1'b0);
        run_n(1);
        start = 1'b0;
        program_selection = 3'b111;
        run_all();

        // cold wash without soap, soap arrives after 10 cycles
        program_selection = 3'b000;
        soap = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 10; i++)
            exp_q.push_back(ov(1'b0, 1'b0, 1'b0, 2'b00, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1));
        run_n(1);
        start = 1'b0;
        run_n(9);
        soap = 1'b1;
        push_wash(1'b0);
        run_all();

        // hot wash with door, soap and start disturbed mid-program
        program_selection = 3'b001;
        start = 1'b1;
        push_wash(1'b1);
        run_n(1);
        start = 1'b0;
        soap = 1'b0;
        run_n(20);
        doorclosed = 1'b0;
        start = 1'b1;
        run_n(10);
        doorclosed = 1'b1;
        start = 1'b0;
        run_all();
        soap = 1'b1;

        // rinse+dry from DONE, then dry only from DONE
        program_selection = 3'b010;
        start = 1'b1;
        push_rinse_dry();
        run_n(1);
        start = 1'b0;
        run_all();
        program_selection = 3'b011;
        start = 1'b1;
        push_spin_done();
        run_n(1);
        start = 1'b0;
        run_all();

        // power off from DONE, then start guards in IDLE
        power = 1'b0;
        push_idle(1);
        run_all();
        check("poweroff_state", 32'(dut.current_state), 32'd0);
        power = 1'b1;
        doorclosed = 1'b0;
        program_selection = 3'b000;
        start = 1'b1;
        push_idle(3);
        run_all();
        doorclosed = 1'b1;
        program_selection = 3'b100;
        push_idle(3);
        run_all();
        program_selection = 3'b000;
        power = 1'b0;
        push_idle(2);
        run_all();
        start = 1'b0;
        power = 1'b1;

        // power loss mid-WASH, power return alone does not restart
        start = 1'b1;
        push_phase(1'b1, 1'b0, 1'b0, 2'b00, 1'b1, FILL_T, FILL_T);
        push_phase(1'b0, 1'b0, 1'b0, 2'b01, 1'b0, WASH_T, 5);
        run_n(1);
        start = 1'b0;
        run_all();
        power = 1'b0;
        push_idle(1);
        run_all();
        check("midwash_poweroff_state", 32'(dut.current_state), 32'd0);
        power = 1'b1;
        push_idle(3);
        run_all();

        // asynchronous reset mid-RINSE, observed between clock edges
        program_selection = 3'b010;
        start = 1'b1;
        push_phase(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, FILL_T, FILL_T);
        push_phase(1'b0, 1'b0, 1'b0, 2'b01, 1'b0, RINSE_T, 5);
        run_n(1);
        start = 1'b0;
        run_all();
        #3;
        rst = 1'b0;
        #1;
        check("async_reset_outputs", 32'(obs), 32'd0);
        check("async_reset_state", 32'(dut.current_state), 32'd0);
        #2;
        rst = 1'b1;
        push_idle(2);
        run_all();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/washer_fsm.md
Name: washer_fsm

Overview:
Washing-machine program controller. It accepts a program selection and a start command, then sequences the fill, wash, drain, rinse and spin phases. It drives the water valves, the motor, the soap dispenser and the door lock, and shows the remaining time of the current phase. It sits between the front-panel inputs and the appliance actuators.

Parameters:
FILL_T, 10, cycles in each fill phase (wash fill and rinse fill)
WASH_T, 30, cycles of wash agitation
DRAIN_T, 10, cycles in each drain phase
RINSE_T, 20, cycles of rinse agitation
SPIN_T, 20, cycles of spin-dry
All phase parameters must be in the range 1..255.

Ports:
clk  in  1  system clock; all state changes on the rising edge
rst  in  1  reset; asynchronous, active-low; forces IDLE and clears all outputs
power  in  1  mains enable; 0 aborts any program
program_selection  in  3  000 cold wash, 001 hot wash, 010 rinse+dry, 011 dry only, 1xx invalid
start  in  1  level-sampled start request
doorclosed  in  1  1 = door closed
soap  in  1  1 = detergent present in drawer
valve_in_cold  out  1  cold inlet valve open
valve_in_hot  out  1  hot inlet valve open
valve_out  out  1  drain valve open
motor  out  2  00 off, 01 wash/rinse agitate, 10 spin, 11 never driven
timer_display  out  8  remaining cycles in the current phase
program_done  out  1  program completed
soap_warning  out  1  wash program is waiting for soap
soap_in  out  1  detergent dispense active
lockDoor  out  1  door lock engaged

Behaviour:
- Internal state register is named current_state, 4 bits wide:
  - IDLE=0, WAIT_SOAP=1, FILL=2, WASH=3, DRAIN1=4, RFILL=5, RINSE=6, DRAIN2=7, SPIN=8, DONE=9.
- Reset (rst=0): asynchronously enter IDLE. Every output is 0, including timer_display=0.
- Start acceptance: in IDLE or DONE, a rising clk with power=1, start=1, doorclosed=1 and program_selection[2]=0 accepts a start.
  - program_selection is latched at that edge. Later changes to it are ignored until the next start.
  - Any other combination leaves the current state unchanged.
- First state after an accepted start:
  - Wash programs (000, 001): FILL if soap=1, otherwise WAIT_SOAP.
  - Rinse+dry (010): RFILL.
  - Dry only (011): SPIN.
- WAIT_SOAP: soap_warning=1, lockDoor=1, all valves and motor off. Go to FILL on the first edge where soap=1; no timeout.
- Phase states (FILL, WASH, DRAIN1, RFILL, RINSE, DRAIN2, SPIN):
  - On entry, timer_display is loaded with the phase length minus 1.
  - It decrements once per cycle. The state advances on the edge where the counter is 0, so each phase lasts exactly its parameter in cycles.
- Phase sequence: FILL→WASH→DRAIN1→RFILL→RINSE→DRAIN2→SPIN→DONE.
- Outputs per state (anything not listed is 0):
  - FILL: valve_in_cold=1 for program 000 or valve_in_hot=1 for program 001; soap_in=1; motor=00.
  - WASH and RINSE: motor=01.
  - RFILL: valve_in_cold=1.
  - DRAIN1 and DRAIN2: valve_out=1.
  - SPIN: valve_out=1, motor=10.
- lockDoor=1 in every state except IDLE and DONE. While lockDoor=1, doorclosed changes are ignored.
- soap changes after FILL is entered are ignored.
- DONE: program_done=1, timer_display=0, all actuators off. The state holds until a new accepted start (which goes straight to that program's first state) or until power=0 (which goes to IDLE).
- power=0 in any state: on the next edge go to IDLE, with all outputs 0 and the counter cleared. power=1 alone does not restart; a new start is required.
- start=1 while a program is running is ignored.
- All outputs are registered or decoded from current_state only; there is no combinational path from inputs to outputs except through state.
- Total durations with default parameters:
  - Wash program with soap present: 110 cycles.
  - Rinse+dry: 60 cycles.
  - Dry only: 20 cycles.

Test Plan:
1. Cold wash with soap: rst pulse low, power=1, doorclosed=1, soap=1, start 1 cycle with sel=000. Required:
   - FILL for 10 cycles with valve_in_cold=1, soap_in=1, lockDoor=1.
   - Then WASH (motor=01) 30, DRAIN1 10, RFILL 10, RINSE 20, DRAIN2 10, SPIN (motor=10, valve_out=1) 20.
   - program_done=1 at cycle 110; lockDoor=0.
2. Cold wash without soap: start with sel=000, soap=0. Required:
   - WAIT_SOAP with soap_warning=1 and all valves off.
   - soap=1 after 10 cycles → FILL on the next edge, then the full sequence; soap_warning=0.
3. Hot wash: sel=001, soap=1. Required: FILL drives valve_in_hot=1 and valve_in_cold=0; RFILL uses cold only.
4. Rinse+dry sel=010 and dry-only sel=011, each started from DONE. Required:
   - Rinse+dry: RFILL→RINSE→DRAIN2→SPIN, program_done after 60 cycles.
   - Dry only: SPIN only, done after 20 cycles; timer_display counts 19→0 during SPIN.
5. Guards:
   - start with doorclosed=0, or with sel=1xx, or with power=0 → stays IDLE.
   - doorclosed toggled mid-program → sequence unaffected.
   - power=0 mid-WASH → IDLE next edge, all outputs 0.
6. Asynchronous reset mid-RINSE: rst low between clock edges → current_state=IDLE and outputs 0 immediately, without waiting for a clock edge.
